// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared encodings for the tile matching game core
// Purpose: mode output codes, play-state enumeration and the state-to-mode mapping.
package tile_pkg;

  localparam logic [1:0] MODE_MENU = 2'd0;
  localparam logic [1:0] MODE_PLAY = 2'd1;
  localparam logic [1:0] MODE_END  = 2'd2;

  typedef enum logic [2:0] {
    ST_MENU,
    ST_P_IDLE,
    ST_P_ONE,
    ST_P_SHOW,
    ST_END
  } state_e;

  function automatic logic [1:0] mode_of(input state_e s);
    case (s)
      ST_MENU: return MODE_MENU;
      ST_END:  return MODE_END;
      default: return MODE_PLAY;
    endcase
  endfunction

endpackage

// File: rtl/show_timer.sv
// rtl/show_timer.sv - loadable down counter with a done pulse
// Purpose: times the reveal period (and the blink period when blinking is built in).
// Ports: clk_i clock; reset_i sync active-high reset; load_i/load_val_i reload the count;
//        en_i counts down toward zero; done_o pulses while enabled with the count at zero.
module show_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = en_i && (count_q == '0);

endmodule

// File: rtl/tile_match_core.sv
// rtl/tile_match_core.sv - memory-style tile pair matching game controller
// Purpose: menu / play / end flow, two-tile selection, timed reveal, pair scoring.
// Ports: CLOCK_50 clock; reset sync active-high; start, quit game control; sel_valid/sel_idx
//        tile selection with sel_ready handshake and sel_err reject pulse; tile_colors latched
//        at start; mode, shown, matched, moves, all_matched status outputs.
// Build option: TILE_BLINK_EN makes mismatched tiles blink during the reveal.
module tile_match_core
  import tile_pkg::*;
#(
  parameter int N_TILES     = 10,
  parameter int COLOR_W     = 3,
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int SCORE_W     = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         quit,
  input  logic                         sel_valid,
  input  logic [$clog2(N_TILES)-1:0]   sel_idx,
  input  logic [N_TILES*COLOR_W-1:0]   tile_colors,
  output logic                         sel_ready,
  output logic                         sel_err,
  output logic [1:0]                   mode,
  output logic [N_TILES-1:0]           shown,
  output logic [N_TILES-1:0]           matched,
  output logic [SCORE_W-1:0]           moves,
  output logic                         all_matched
);

  localparam int IDX_W = $clog2(N_TILES);
  localparam int TW    = $clog2(SHOW_CYCLES);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(SHOW_CYCLES - 1);

  state_e               state_q, state_d;
  logic [N_TILES-1:0]   matched_q, matched_d;
  logic [N_TILES-1:0]   flipped_q, flipped_d;
  logic [SCORE_W-1:0]   moves_q, moves_d;
  logic [IDX_W-1:0]     first_q, first_d;
  logic [IDX_W-1:0]     second_q, second_d;
  logic                 sel_err_q, sel_err_d;
  logic [COLOR_W-1:0]   col_q [N_TILES];

  logic                 latch_colors;
  logic                 timer_load;
  logic                 timer_done;
  logic                 in_show;
  logic                 colors_differ;
  logic [N_TILES-1:0]   sel_onehot;
  logic                 sel_bad;

  assign in_show       = (state_q == ST_P_SHOW);
  assign colors_differ = (col_q[first_q] != col_q[second_q]);

  // One-hot decode of the offered index; an all-zero result means out of range.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N_TILES; i++) begin
      sel_onehot[i] = (sel_idx == IDX_W'(i));
    end
  end

  assign sel_bad = (sel_onehot == '0) || ((sel_onehot & matched_q) != '0) ||
                   ((state_q == ST_P_ONE) && (sel_idx == first_q));

  show_timer #(.W(TW)) u_show_timer (
    .clk_i      (CLOCK_50),
    .reset_i    (reset),
    .load_i     (timer_load),
    .load_val_i (SHOW_LOAD),
    .en_i       (in_show),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    matched_d    = matched_q;
    flipped_d    = flipped_q;
    moves_d      = moves_q;
    first_d      = first_q;
    second_d     = second_q;
    sel_err_d    = 1'b0;
    latch_colors = 1'b0;
    timer_load   = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (start) begin
          latch_colors = 1'b1;
          matched_d    = '0;
          flipped_d    = '0;
          moves_d      = '0;
          state_d      = ST_P_IDLE;
        end
      end
      ST_P_IDLE, ST_P_ONE: begin
        // quit wins over a selection offered in the same cycle
        if (quit) begin
          flipped_d = '0;
          state_d   = ST_MENU;
        end else if (sel_valid) begin
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else if (state_q == ST_P_IDLE) begin
            first_d   = sel_idx;
            flipped_d = flipped_q | sel_onehot;
            state_d   = ST_P_ONE;
          end else begin
            second_d   = sel_idx;
            flipped_d  = flipped_q | sel_onehot;
            timer_load = 1'b1;
            if (moves_q != '1) begin
              moves_d = moves_q + 1'b1;
            end
            state_d = ST_P_SHOW;
          end
        end
      end
      ST_P_SHOW: begin
        if (quit) begin
          flipped_d = '0;
          state_d   = ST_MENU;
        end else if (timer_done) begin
          flipped_d = '0;
          state_d   = ST_P_IDLE;
          if (!colors_differ) begin
            matched_d = matched_q | flipped_q;
            if (&matched_d) begin
              state_d = ST_END;
            end
          end
        end
      end
      ST_END: begin
        if (quit || start) begin
          state_d = ST_MENU;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_MENU;
      matched_q <= '0;
      flipped_q <= '0;
      moves_q   <= '0;
      first_q   <= '0;
      second_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      matched_q <= matched_d;
      flipped_q <= flipped_d;
      moves_q   <= moves_d;
      first_q   <= first_d;
      second_q  <= second_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Colour snapshot for the whole game; the live input is ignored after start.
  always_ff @(posedge CLOCK_50) begin
    if (latch_colors) begin
      for (int i = 0; i < N_TILES; i++) begin
        col_q[i] <= tile_colors[i*COLOR_W +: COLOR_W];
      end
    end
  end

`ifdef TILE_BLINK_EN
  localparam int BLINK_CYCLES = (SHOW_CYCLES / 8 > 0) ? SHOW_CYCLES / 8 : 1;
  localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_CYCLES - 1);

  logic blink_done;
  logic blink_q, blink_d;

  show_timer #(.W(TW)) u_blink_timer (
    .clk_i      (CLOCK_50),
    .reset_i    (reset),
    .load_i     (timer_load | blink_done),
    .load_val_i (BLINK_LOAD),
    .en_i       (in_show),
    .done_o     (blink_done)
  );

  // Phase restarts "on" at every reveal, then flips on each blink period.
  always_comb begin
    blink_d = blink_q;
    if (timer_load) begin
      blink_d = 1'b1;
    end else if (blink_done) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign shown = matched_q |
                 (flipped_q & {N_TILES{blink_q || !(in_show && colors_differ)}});
`else
  assign shown = matched_q | flipped_q;
`endif

  assign sel_ready   = (state_q == ST_P_IDLE) || (state_q == ST_P_ONE);
  assign sel_err     = sel_err_q;
  assign mode        = mode_of(state_q);
  assign matched     = matched_q;
  assign moves       = moves_q;
  assign all_matched = (state_q == ST_END);

endmodule

// File: tb/tb_tile_match_core.sv
// tb/tb_tile_match_core.sv - scoreboard bench for tile_match_core against a game-rule model
module tb_tile_match_core;

  localparam int NT = 4;
  localparam int CW = 2;
  localparam int SC = 4;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] shown;
    logic [3:0] matched;
    logic [7:0] moves8;
    logic [1:0] moves2;
    logic       sel_ready;
    logic       sel_err;
    logic       all_matched;
  } exp_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, start = 1'b0, quit = 1'b0, sel_valid = 1'b0;
  logic [1:0] sel_idx = '0;
  logic [7:0] tile_colors;
  logic       sel_ready, sel_err, all_matched;
  logic [1:0] mode;
  logic [3:0] shown, matched;
  logic [7:0] moves;
  logic       s_ready, s_err, s_all;
  logic [1:0] s_mode, s_moves;
  logic [3:0] s_shown, s_matched;

  localparam logic [7:0] FIXED_COL = 8'b01_00_01_00;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // game model: phase 0 menu, 1 no tile up, 2 one tile up, 3 revealing, 4 finished
  int       ph = 0;
  int       first_t = 0, second_t = 0, reveal_left = 0, attempts = 0;
  bit [3:0] m_mat = '0, m_flp = '0;
  int       colour [NT];
  bit       m_err = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  tile_match_core #(.N_TILES(NT), .COLOR_W(CW), .SHOW_CYCLES(SC), .SCORE_W(8)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .quit(quit),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .tile_colors(tile_colors),
    .sel_ready(sel_ready), .sel_err(sel_err), .mode(mode), .shown(shown),
    .matched(matched), .moves(moves), .all_matched(all_matched)
  );

  tile_match_core #(.N_TILES(NT), .COLOR_W(CW), .SHOW_CYCLES(SC), .SCORE_W(2)) dut_s (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .quit(quit),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .tile_colors(tile_colors),
    .sel_ready(s_ready), .sel_err(s_err), .mode(s_mode), .shown(s_shown),
    .matched(s_matched), .moves(s_moves), .all_matched(s_all)
  );

  task automatic model_next(input bit r, input bit st, input bit q, input bit sv,
                            input int idx, input logic [7:0] cols);
    m_err = 1'b0;
    if (r) begin
      ph = 0; m_mat = '0; m_flp = '0; attempts = 0;
    end else begin
      case (ph)
        0: if (st) begin
          for (int i = 0; i < NT; i++) colour[i] = int'(cols[i*CW +: CW]);
          m_mat = '0; m_flp = '0; attempts = 0; ph = 1;
        end
        1, 2: if (q) begin
          m_flp = '0; ph = 0;
        end else if (sv) begin
          if (m_mat[idx] || (ph == 2 && idx == first_t)) m_err = 1'b1;
          else if (ph == 1) begin
            first_t = idx; m_flp[idx] = 1'b1; ph = 2;
          end else begin
            second_t = idx; m_flp[idx] = 1'b1; attempts++; reveal_left = SC; ph = 3;
          end
        end
        3: if (q) begin
          m_flp = '0; ph = 0;
        end else begin
          reveal_left--;
          if (reveal_left == 0) begin
            if (colour[first_t] == colour[second_t]) m_mat = m_mat | m_flp;
            m_flp = '0;
            ph = (m_mat == 4'hF) ? 4 : 1;
          end
        end
        default: if (q || st) ph = 0;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mode        = (ph == 0) ? 2'd0 : (ph == 4) ? 2'd2 : 2'd1;
    e.shown       = m_mat | m_flp;
    e.matched     = m_mat;
    e.moves8      = (attempts > 255) ? 8'd255 : 8'(attempts);
    e.moves2      = (attempts > 3) ? 2'd3 : 2'(attempts);
    e.sel_ready   = (ph == 1) || (ph == 2);
    e.sel_err     = m_err;
    e.all_matched = (ph == 4);
    return e;
  endfunction

  // One clock of stimulus; the expectation for the state after the coming edge is queued.
  task automatic step(input bit r, input bit st, input bit q, input bit sv,
                      input int idx, input bit rnd_col);
    reset = r; start = st; quit = q; sel_valid = sv; sel_idx = 2'(idx);
    if (st && !rnd_col) tile_colors = FIXED_COL;
    else tile_colors = ($urandom_range(1) == 1) ? 8'($urandom) : FIXED_COL;
    model_next(r, st, q, sv, idx, tile_colors);
    exp_q.push_back(model_out());
    @(posedge CLOCK_50); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic pick(input int idx);
    step(0, 0, 0, 1, idx, 0);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLOCK_50); #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mode",        int'(mode),        int'(e.mode));
        check("shown",       int'(shown),       int'(e.shown));
        check("matched",     int'(matched),     int'(e.matched));
        check("moves",       int'(moves),       int'(e.moves8));
        check("moves_sat2",  int'(s_moves),     int'(e.moves2));
        check("sel_ready",   int'(sel_ready),   int'(e.sel_ready));
        check("sel_err",     int'(sel_err),     int'(e.sel_err));
        check("all_matched", int'(all_matched), int'(e.all_matched));
      end
    end
  end

  initial begin : driver
    tile_colors = FIXED_COL;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 2, 0);
    idle(1);
    // mismatch, then match, then rejected picks, then finish the board
    step(0, 1, 0, 0, 0, 0);
    pick(0); pick(1); idle(5);
    pick(0); pick(2); idle(5);
    pick(1); pick(1); pick(0); pick(2); pick(3); idle(5);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    idle(1);
    // second game ending with quit from the end screen
    step(0, 1, 0, 0, 0, 0);
    pick(0); pick(2); idle(5); pick(3); pick(1); idle(5);
    step(0, 0, 1, 0, 0, 0);
    idle(1);
    // quit beats a simultaneous selection; reset aborts a reveal
    step(0, 1, 0, 0, 0, 0);
    pick(0);
    step(0, 0, 1, 1, 1, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0);
    pick(0); pick(2); idle(2);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // five failed attempts saturate the narrow counter
    step(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      pick(0); pick(1); idle(5);
    end
    // random play
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(299) == 0, $urandom_range(7) == 0, $urandom_range(39) == 0,
           $urandom_range(1) == 1, int'($urandom_range(3)), $urandom_range(3) == 0);
    end
    idle(1);
    repeat (2) @(posedge CLOCK_50);
    #4;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
